// File: rtl/sparc_exu_ecl_yreg_ctl.sv
// Y-register write-control sequencer for a 4-thread core.
// Tracks WRY and MULScc from E to W2, applies the M and W kills, and
// arbitrates against multiplier Y writebacks arriving in G. Produces
// one-hot-per-thread selects for the storage block's next-value muxes.
module sparc_exu_ecl_yreg_ctl #(
  parameter int NTHR = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifu_exu_wy_e,
  input  logic            ifu_exu_muls_e,
  input  logic [NTHR-1:0] ecl_thr_e,
  input  logic            byp_ecl_rs1_0_e,
  input  logic            ecl_kill_m,
  input  logic            ecl_kill_w,
  input  logic            mul_ecl_yreg_vld_g,
  input  logic [NTHR-1:0] mul_ecl_yreg_thr_g,
  output logic [NTHR-1:0] ecl_div_yreg_wen_w,
  output logic [NTHR-1:0] ecl_div_yreg_wen_g,
  output logic [NTHR-1:0] ecl_div_yreg_wen_l,
  output logic [NTHR-1:0] ecl_div_yreg_shift_g,
  output logic            ecl_div_yreg_data_31_g,
  output logic            ecl_mul_yreg_stall_g
);

  // One in-flight Y operation as it moves down the pipe.
  typedef struct packed {
    logic            vld_wy;
    logic            vld_muls;
    logic [NTHR-1:0] thr;
    logic            rs1_0;
  } yop_t;

  yop_t e_op;
  yop_t m_q;
  yop_t w_q;
  yop_t w2_q;

  logic [NTHR-1:0] pre_w;
  logic [NTHR-1:0] pre_sh;
  logic            conflict;

  // Form the E-stage operation; MULScc wins if both decodes fire.
  always_comb begin
    e_op          = '0;
    e_op.vld_muls = ifu_exu_muls_e;
    e_op.vld_wy   = ifu_exu_wy_e & ~ifu_exu_muls_e;
    e_op.thr      = ecl_thr_e;
    e_op.rs1_0    = byp_ecl_rs1_0_e;
  end

  // Advance E->M->W->W2; each kill clears only the entry in its own stage.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every stage sample the previous
    // stage's old value, so the shift register advances one step per clock.
    if (reset) begin
      m_q  <= '0;
      w_q  <= '0;
      w2_q <= '0;
    end else begin
      m_q <= e_op;

      w_q          <= m_q;
      w_q.vld_wy   <= m_q.vld_wy   & ~ecl_kill_m;
      w_q.vld_muls <= m_q.vld_muls & ~ecl_kill_m;

      w2_q          <= w_q;
      w2_q.vld_wy   <= w_q.vld_wy   & ~ecl_kill_w;
      w2_q.vld_muls <= w_q.vld_muls & ~ecl_kill_w;
    end
  end

  // Per-thread selects from W2 plus the G-stage multiplier writeback.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave a value
    // unassigned and infer a latch.
    pre_w                  = '0;
    pre_sh                 = '0;
    conflict               = 1'b0;
    ecl_div_yreg_wen_w     = '0;
    ecl_div_yreg_wen_g     = '0;
    ecl_div_yreg_shift_g   = '0;
    ecl_div_yreg_data_31_g = 1'b0;
    ecl_mul_yreg_stall_g   = 1'b0;

    // W2 ops are suppressed while reset is asserted; the flops clear at the
    // reset edge, which covers the following cycle.
    if (!reset) begin
      pre_w  = {NTHR{w2_q.vld_wy}}   & w2_q.thr;
      pre_sh = {NTHR{w2_q.vld_muls}} & w2_q.thr;
    end

    conflict = mul_ecl_yreg_vld_g & (|(mul_ecl_yreg_thr_g & (pre_w | pre_sh)));

    ecl_div_yreg_wen_w     = pre_w;
    ecl_div_yreg_shift_g   = pre_sh;
    ecl_div_yreg_data_31_g = (w2_q.vld_muls & ~reset) ? w2_q.rs1_0 : 1'b0;
    ecl_div_yreg_wen_g     = (mul_ecl_yreg_vld_g & ~conflict) ? mul_ecl_yreg_thr_g : '0;
    ecl_mul_yreg_stall_g   = conflict;
  end

  assign ecl_div_yreg_wen_l = ~(ecl_div_yreg_wen_w | ecl_div_yreg_wen_g | ecl_div_yreg_shift_g);

endmodule

// File: tb/tb_sparc_exu_ecl_yreg_ctl.sv
// Directed bench for sparc_exu_ecl_yreg_ctl: a per-cycle vector table
// plus a hand-written repeated-conflict stall sequence.
module tb_sparc_exu_ecl_yreg_ctl;

  localparam int NTHR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            wy_e, muls_e, rs1_0_e, kill_m, kill_w, mvld;
  logic [NTHR-1:0] thr_e, mthr;
  logic [NTHR-1:0] wen_w, wen_g, wen_l, shift_g;
  logic            data_31, stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sparc_exu_ecl_yreg_ctl #(.NTHR(NTHR)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ifu_exu_wy_e           (wy_e),
    .ifu_exu_muls_e         (muls_e),
    .ecl_thr_e              (thr_e),
    .byp_ecl_rs1_0_e        (rs1_0_e),
    .ecl_kill_m             (kill_m),
    .ecl_kill_w             (kill_w),
    .mul_ecl_yreg_vld_g     (mvld),
    .mul_ecl_yreg_thr_g     (mthr),
    .ecl_div_yreg_wen_w     (wen_w),
    .ecl_div_yreg_wen_g     (wen_g),
    .ecl_div_yreg_wen_l     (wen_l),
    .ecl_div_yreg_shift_g   (shift_g),
    .ecl_div_yreg_data_31_g (data_31),
    .ecl_mul_yreg_stall_g   (stall)
  );

  typedef struct {
    logic       rst, wy, mu;
    logic [3:0] thr;
    logic       rs1, km, kw, mv;
    logic [3:0] mt;
    logic [3:0] ew, eg, el, esh;
    logic       ed, es;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, wy, mu, input logic [3:0] thr, input logic rs1, km, kw, mv,
                     input logic [3:0] mt, ew, eg, el, esh, input logic ed, es);
    vec_t v;
    v.rst = rst; v.wy = wy; v.mu = mu; v.thr = thr; v.rs1 = rs1; v.km = km; v.kw = kw;
    v.mv = mv; v.mt = mt; v.ew = ew; v.eg = eg; v.el = el; v.esh = esh; v.ed = ed; v.es = es;
    tbl.push_back(v);
  endtask

  // Idle cycle expecting all threads to hold.
  task automatic idle();
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
  endtask

  task automatic drive(input logic rst, wy, mu, input logic [3:0] thr, input logic rs1, km, kw, mv,
                       input logic [3:0] mt);
    reset = rst; wy_e = wy; muls_e = mu; thr_e = thr; rs1_0_e = rs1;
    kill_m = km; kill_w = kw; mvld = mv; mthr = mt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Exactly one select per thread, every cycle.
  always @(negedge clk) begin
    for (int t = 0; t < NTHR; t++) begin
      check($sformatf("onehot_thr%0d", t),
            32'(wen_w[t]) + 32'(wen_g[t]) + 32'(wen_l[t]) + 32'(shift_g[t]), 32'd1);
    end
  end

  initial begin
    int stalls;
    int granted;

    drive(1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000);
    next_cycle();
    next_cycle();

    // Reset with a multiplier writeback present: wen_g follows input, no stall.
    add(1, 0, 0, 4'b0000, 0, 0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 4'b1101, 4'b0000, 0, 0);
    idle();
    // WRY thr 0010: select three cycles later only.
    add(0, 1, 0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 0, 0);
    idle();
    // MULScc thr 1000 shifting in a one.
    add(0, 0, 1, 4'b1000, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1000, 1, 0);
    idle();
    // WRY killed in M.
    add(0, 1, 0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    // WRY killed in W.
    add(0, 1, 0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle();
    add(0, 0, 0, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle();
    // kill_m hits the op in M only; the younger op in E survives.
    add(0, 1, 0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    add(0, 1, 0, 4'b0010, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 0, 0);
    // WRY thr 0100 vs same-thread multiplier: stall, then grant on the held request.
    add(0, 1, 0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    add(0, 0, 0, 4'b0000, 0, 0, 0, 1, 4'b0100, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 0, 0, 1, 4'b0100, 4'b0000, 4'b0100, 4'b1011, 4'b0000, 0, 0);
    idle();
    // Different threads proceed together.
    add(0, 1, 0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    add(0, 0, 0, 4'b0000, 0, 0, 0, 1, 4'b0001, 4'b0100, 4'b0001, 4'b1010, 4'b0000, 0, 0);
    idle();
    // MULScc vs same-thread multiplier also stalls.
    add(0, 0, 1, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    add(0, 0, 0, 4'b0000, 0, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 0, 0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 0, 0);
    // WRY and MULScc together: MULScc wins.
    add(0, 1, 1, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 1, 0);
    // Reset mid-operation discards three in-flight ops, then normal service resumes.
    add(0, 1, 0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    add(0, 0, 1, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    add(1, 1, 0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle(); idle();
    add(0, 1, 0, 4'b1000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0111, 4'b0000, 0, 0);
    // Reset asserted in the very cycle an op sits in W2: its select is suppressed.
    add(0, 1, 0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle(); idle();
    add(1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    idle();
    // Back-to-back ops on four threads, no bubbles.
    add(0, 1, 0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    add(0, 0, 1, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    add(0, 1, 0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    add(0, 0, 1, 4'b1000, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1000, 0, 0);
    idle();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].wy, tbl[i].mu, tbl[i].thr, tbl[i].rs1,
            tbl[i].km, tbl[i].kw, tbl[i].mv, tbl[i].mt);
      #3;
      check($sformatf("row%0d_wen_w", i),   32'(wen_w),   32'(tbl[i].ew));
      check($sformatf("row%0d_wen_g", i),   32'(wen_g),   32'(tbl[i].eg));
      check($sformatf("row%0d_wen_l", i),   32'(wen_l),   32'(tbl[i].el));
      check($sformatf("row%0d_shift", i),   32'(shift_g), 32'(tbl[i].esh));
      check($sformatf("row%0d_data31", i),  32'(data_31), 32'(tbl[i].ed));
      check($sformatf("row%0d_stall", i),   32'(stall),   32'(tbl[i].es));
      next_cycle();
    end

    // Two MULScc on thread 0010 back to back against a held multiplier
    // writeback on the same thread: two stall cycles, then the grant.
    drive(0, 0, 1, 4'b0010, 1, 0, 0, 0, 4'b0000);
    next_cycle();
    drive(0, 0, 1, 4'b0010, 0, 0, 0, 0, 4'b0000);
    next_cycle();
    drive(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000);
    next_cycle();
    drive(0, 0, 0, 4'b0000, 0, 0, 0, 1, 4'b0010);
    stalls  = 0;
    granted = 0;
    for (int n = 0; n < 6 && granted == 0; n++) begin
      #3;
      if (n == 0) check("seq_first_data31", 32'(data_31), 32'd1);
      if (n == 1) check("seq_second_data31", 32'(data_31), 32'd0);
      if (stall === 1'b1) stalls++;
      if (wen_g === 4'b0010) granted = 1;
      next_cycle();
    end
    check("seq_granted", 32'(granted), 32'd1);
    check("seq_stall_cycles", 32'(stalls), 32'd2);
    drive(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000);
    #3;
    check("seq_idle_wen_l", 32'(wen_l), 32'hF);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sparc_exu_ecl_yreg_ctl.md
Name: sparc_exu_ecl_yreg_ctl

Overview:
- Per-thread write-control sequencer for the 4-thread Y-register file; sits directly upstream of the Y-register storage block.
- Tracks WRY and MULScc through E→M→W→W2, applies pipeline kills, and arbitrates against multiplier Y writebacks returning in G.
- Produces the one-hot-per-thread select set for the storage block's 4:1 next-value muxes (write-W, write-G, hold, shift).

Parameters:
- NTHR, 4, number of hardware threads; width of all thread vectors.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- ifu_exu_wy_e  in  1  WRY instruction valid in E
- ifu_exu_muls_e  in  1  MULScc instruction valid in E
- ecl_thr_e  in  NTHR  one-hot thread of the E-stage instruction
- byp_ecl_rs1_0_e  in  1  rs1[0] of the E-stage instruction (the MULScc shift-in bit)
- ecl_kill_m  in  1  flush of the M-stage instruction
- ecl_kill_w  in  1  trap/flush of the W-stage instruction
- mul_ecl_yreg_vld_g  in  1  multiplier Y writeback valid
- mul_ecl_yreg_thr_g  in  NTHR  one-hot thread of the multiplier writeback
- ecl_div_yreg_wen_w  out  NTHR  select registered W data (W2 cycle)
- ecl_div_yreg_wen_g  out  NTHR  select multiplier data
- ecl_div_yreg_wen_l  out  NTHR  hold current value
- ecl_div_yreg_shift_g  out  NTHR  MULScc right-shift
- ecl_div_yreg_data_31_g  out  1  bit shifted into Y[31]
- ecl_mul_yreg_stall_g  out  1  multiplier must hold its writeback one more cycle

Behaviour:
- Pipeline regs E→M, M→W, W→W2 each carry {vld_wy, vld_muls, thr[NTHR-1:0], rs1_0}.
- E→M captures the E inputs; vld bits qualify on wy/muls.
- M→W: vld bits cleared when ecl_kill_m=1.
- W→W2: vld bits cleared when ecl_kill_w=1.
- Kills affect only the instruction in that stage; older/younger entries are untouched.
- wy_e and muls_e both high in the same cycle: illegal; muls takes precedence and wy is dropped.
- Per-thread outputs, derived from W2 flops with combinational G terms:
  - pre_w[t]  = w2_vld_wy & w2_thr[t]
  - pre_sh[t] = w2_vld_muls & w2_thr[t]
  - conflict = mul_ecl_yreg_vld_g & |(mul_ecl_yreg_thr_g & (pre_w|pre_sh))
  - wen_w = pre_w
  - shift_g = pre_sh
  - data_31_g = w2_rs1_0 when w2_vld_muls, else 0
  - wen_g = mul_ecl_yreg_vld_g & ~conflict ? mul_ecl_yreg_thr_g : 0
  - stall_g = conflict
  - wen_l = ~(wen_w | wen_g | shift_g)
- Invariant: for every thread exactly one of {wen_w, wen_g, wen_l, shift_g} is 1 each cycle. The bench asserts this every cycle.
- Latency:
  - WRY/MULScc in E at cycle n → select asserted in cycle n+3, aligned with the storage block's registered W data. The Y update is visible at cycle n+4.
  - Multiplier writeback: same cycle as vld_g unless stalled.
- Stall handshake: when stall_g=1, the multiplier holds vld/thr/data unchanged next cycle.
- Repeated conflict keeps stalling. Bound: at most one cycle per W2 Y-op on that thread, so no livelock.
- Different-thread G and W2 events in the same cycle both proceed with no stall.
- Reset: all pipeline valid bits cleared. Outputs during and in the cycle after reset:
  - wen_w, wen_g, shift_g = 0
  - wen_l = all-ones
  - data_31_g = 0
  - stall_g = 0
- Reset mid-operation discards in-flight ops; no Y select is issued for them.
- mul_ecl_yreg_vld_g during reset: wen_g still follows the input (storage is don't-care under reset). stall_g = 0.
- Back-to-back ops (one per cycle, any threads) are supported with no bubbles.

Test Plan:
- WRY thr=0010 in E at cycle 10, no kills → wen_w=0010 at cycle 13 only; wen_l=1101 at 13; wen_l=1111 at all other cycles.
- MULScc thr=1000, rs1_0=1, E at cycle 5 → shift_g=1000 and data_31_g=1 at cycle 8; wen_l=0111 at cycle 8.
- WRY thr=0001 in E at 20 with ecl_kill_m=1 at 21 → no wen_w at 23. Repeat with ecl_kill_w=1 at 22 → also no wen_w.
- WRY thr=0100 in E at 30; mul vld_g thr=0100 at 33 → stall_g=1, wen_g=0000, wen_w=0100 at 33. Mul holds → wen_g=0100, stall_g=0 at 34.
- Same as above but mul thr=0001 at 33 → wen_w=0100 and wen_g=0001 together, stall_g=0.
- Three ops in E at cycles 40–42 (thr 0001/0010/0100); reset=1 at cycle 42 → no selects issued at 43–45, all wen_l=1111, then normal operation resumes.
